// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier datapath and its dot-product accumulator.
// Combinational helpers only; no latency and no handshake.
// Products are PROD_W-bit two's complement values from an OPND_W x OPND_W multiplier.
package booth_pkg;

  localparam int PROD_W = 12;
  localparam int OPND_W = 6;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  // Sign-extends a product to acc_w bits; bits at and above acc_w are returned as 0.
  function automatic logic [31:0] sext_prod(input logic [PROD_W-1:0] prod, input int acc_w);
    logic [31:0] ext;
    logic [31:0] r;
    ext = {{(32-PROD_W){prod[PROD_W-1]}}, prod};
    r   = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < acc_w) r[i] = ext[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Signed W-bit adder with overflow flag; clamps to the signed range when SATURATE_EN is defined.
// Purely combinational, zero latency.
// No handshake; the caller decides when the sum is consumed.
module booth_sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  always_comb begin
    raw = a + b;
    ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef SATURATE_EN
    // Overflow direction follows the shared operand sign.
    if (ovf) sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else     sum = raw;
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/booth_dot_accum.sv
// Dot-product accumulator: sums up to DOT_LEN signed products (SATURATE_EN selects clamping).
// Latency: result valid the cycle after the closing beat; one dead input cycle per vector.
// Backpressure: prod_ready drops while a result waits for res_ready; res_* held until taken.
module booth_dot_accum
  import booth_pkg::*;
#(
  parameter  int DOT_LEN = 16,
  parameter  int ACC_W   = 16,
  localparam int CNT_W   = $clog2(DOT_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_ovf
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOT_LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             res_ovf_q, res_ovf_d;
  logic             run_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             accept;

  assign prod_ext = ACC_W'(sext_prod(prod_data, ACC_W));

  booth_sat_add #(.W(ACC_W)) u_add (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // run_q keeps prod_ready low while reset is applied and until the first edge after it.
  assign prod_ready = run_q && (state_q == ACCUM) && !clr;
  assign accept     = prod_valid && prod_ready;
  assign res_valid  = (state_q == DONE);
  assign res_data   = res_data_q;
  assign res_count  = res_count_q;
  assign res_ovf    = res_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    res_ovf_d   = res_ovf_q;
    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d = add_sum;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | add_ovf;
            if ((cnt_q == CNT_LAST) || prod_last) begin
              res_data_d  = add_sum;
              res_count_d = cnt_q + CNT_W'(1);
              res_ovf_d   = ovf_q | add_ovf;
              state_d     = DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
      res_ovf_q   <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      res_ovf_q   <= res_ovf_d;
      run_q       <= 1'b1;
    end
  end

endmodule
